tile_engine: RTL and testbench
==============================

Name: tile_engine

Overview:
- Parametrised successor to the fixed 4x4 tile processor.
- Streams a TILE x TILE tile of signed operands from SRAM A and SRAM B at strided addresses, applies an element-wise op or a full-tile dot product, and writes results to SRAM C.
- Supports configurable post-shift and saturating or wrapping output.
- Sits between the NPU controller (start/busy/done) and the three single-port SRAMs. SRAM read latency is a fixed 1 cycle.

Parameters:
- DW, 8: operand and result width, signed two's complement.
- AW, 10: SRAM address width.
- TILE, 4: tile side; N = TILE*TILE elements per tile.
- MEM_COLS, 32: row stride of the matrix in SRAM, in elements.
- TIW, 3: width of the tile_i and tile_j indices.
- ACCW, 32: DOT accumulator width. Must be at least 2*DW + clog2(N).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: command strobe; accepted only while busy=0.
- op, in, 3: 0 ADD, 1 SUB, 2 MUL (element-wise), 3 DOT, 4 MAX (element-wise); 5-7 illegal.
- tile_i, in, TIW: tile row index.
- tile_j, in, TIW: tile column index.
- sat_en, in, 1: 1 = saturate result to DW signed; 0 = keep low DW bits (wrap).
- shift, in, clog2(DW): arithmetic right shift applied to MUL and DOT results before saturate/wrap.
- sram_a_addr, out, AW: SRAM A read address.
- sram_b_addr, out, AW: SRAM B read address.
- sram_a_dout, in, DW: SRAM A read data, valid 1 cycle after address.
- sram_b_dout, in, DW: SRAM B read data, valid 1 cycle after address.
- sram_c_we, out, 1: SRAM C write enable.
- sram_c_addr, out, AW: SRAM C write address.
- sram_c_din, out, DW: SRAM C write data.
- busy, out, 1: command in progress.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: one-cycle pulse, coincident with done, for an illegal op.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE. Outputs busy, done, err, sram_c_we = 0; all addresses, sram_c_din, counters and accumulator = 0. Reset asserted mid-command aborts immediately; no further writes.
- Command latch: at the start edge S (start=1, busy=0), latch op, tile_i, tile_j, sat_en and shift. Inputs may change afterwards without effect. start while busy=1 is ignored.
- Addressing:
  - base = tile_i*TILE*MEM_COLS + tile_j*TILE.
  - Element n = r*TILE + c maps to address base + r*MEM_COLS + c, mod 2^AW (wraps silently).
  - A, B and C element-wise outputs use the same address for a given element.
  - DOT writes a single result at base.
- States:
  - IDLE -> READ on accepted legal op.
  - IDLE -> ERR on illegal op.
  - READ issues element n in cycle S+1+n for n = 0..N-1, then -> DRAIN.
  - DRAIN holds 2 cycles: pipeline empties, last write.
  - -> DONE for 1 cycle -> IDLE.
  - ERR holds 1 cycle with done=err=1, no SRAM access, -> IDLE.
- Pipeline (all outputs registered):
  - Address for element n visible in cycle S+1+n.
  - dout sampled in cycle S+2+n.
  - Element-wise: sram_c_we/addr/din for n visible in cycle S+3+n. Writes are back-to-back, N cycles, in ascending n.
  - DOT: acc = sum of A*B across all n (ACCW signed), cleared at accept. A single write is visible in cycle S+2+N; its data is (acc including last product) >>> shift.
- Timing:
  - busy = 1 from S+1 through S+2+N.
  - done = 1 in cycle S+3+N with busy = 0; the engine is in IDLE in that cycle and accepts a new start then.
  - Latency from start to done is N+3 cycles for every legal op.
- Arithmetic:
  - ADD/SUB use a DW+1 bit result. MUL uses 2*DW bits >>> shift. MAX = signed max(A, B), never saturates.
  - Shift is arithmetic, flooring toward -inf, and is ignored for ADD, SUB and MAX.
  - sat_en=1 clamps to [-2^(DW-1), 2^(DW-1)-1]. sat_en=0 takes the low DW bits.
- sram_c_we = 0 in every cycle with no valid write. Address outputs hold their last value when idle.

Test Plan:
- Address sweep: TILE=4, MEM_COLS=32, tile_i=1, tile_j=2, ADD. Require the A/B address sequence 136,137,138,139,168..171,200..203,232..235 in cycles S+1..S+16, C writes to the same addresses in S+3..S+18, done in S+19.
- Saturation: ADD with A=100, B=50 everywhere. sat_en=1 -> all C=127. sat_en=0 -> all C=0x96 (-106). SUB with A=-100, B=50, sat_en=1 -> -128.
- MUL and MAX:
  - MUL with A=20, B=-7, shift=2, sat_en=1 -> C=-35 (-140>>>2).
  - MUL with A=B=-128, shift=0 -> C=127.
  - MAX with A=-3, B=5 -> 5.
- DOT: A=2, B=3 -> one write of 96 at base, cycle S+18. A=B=10, shift=0, sat_en=1 -> 127. The same with shift=4 -> 100.
- Control: illegal op=6 -> done=err=1 in S+1, no we, no address change. start pulsed while busy -> ignored, single done. start in the done cycle -> accepted, second command completes N+3 cycles later.
- Reset mid-op: assert rst at S+8 of an ADD -> busy, done and we fall to 0 immediately, no further writes. A new command after release completes normally.

Source files
------------

// File: rtl/tile_engine.sv
// Tile engine: streams a TILE x TILE tile from SRAM A/B at strided addresses,
// applies an element-wise op or a full-tile dot product, writes results to SRAM C.
module tile_engine #(
  parameter int DW       = 8,
  parameter int AW       = 10,
  parameter int TILE     = 4,
  parameter int MEM_COLS = 32,
  parameter int TIW      = 3,
  parameter int ACCW     = 32,
  localparam int SW      = $clog2(DW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [TIW-1:0] tile_i,
  input  logic [TIW-1:0] tile_j,
  input  logic           sat_en,
  input  logic [SW-1:0]  shift,
  output logic [AW-1:0]  sram_a_addr,
  output logic [AW-1:0]  sram_b_addr,
  input  logic [DW-1:0]  sram_a_dout,
  input  logic [DW-1:0]  sram_b_dout,
  output logic           sram_c_we,
  output logic [AW-1:0]  sram_c_addr,
  output logic [DW-1:0]  sram_c_din,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int N   = TILE * TILE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int CLW = (TILE > 1) ? $clog2(TILE) : 1;

  localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE, ST_ERR} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DOT = 3'd3, OP_MAX = 3'd4
  } op_e;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic                   sat_q, sat_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [AW-1:0]          base_q, base_d, row_q, row_d, addr_q, addr_d;
  logic [AW-1:0]          addr1_q, addr1_d, c_addr_q, c_addr_d;
  logic [CLW-1:0]         col_q, col_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   v1_q, v1_d, last1_q, last1_d, we_q, we_d;
  logic [DW-1:0]          din_q, din_d;
  logic signed [ACCW-1:0] acc_q, acc_d;

  logic [AW-1:0]          base_in;
  logic                   legal;
  logic signed [DW-1:0]   a_s, b_s, max_s;
  logic signed [DW:0]     sum_s, diff_s;
  logic signed [2*DW-1:0] prod_s, prod_sh;
  logic signed [ACCW-1:0] acc_sum, res_w;
  logic [DW-1:0]          res_c;

  always_comb begin
    a_s     = $signed(sram_a_dout);
    b_s     = $signed(sram_b_dout);
    sum_s   = {a_s[DW-1], a_s} + {b_s[DW-1], b_s};
    diff_s  = {a_s[DW-1], a_s} - {b_s[DW-1], b_s};
    prod_s  = {{DW{a_s[DW-1]}}, a_s} * {{DW{b_s[DW-1]}}, b_s};
    prod_sh = prod_s >>> shift_q;
    max_s   = (a_s > b_s) ? a_s : b_s;
    acc_sum = acc_q + {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
    res_w   = '0;
    case (op_q)
      OP_ADD:  res_w = {{(ACCW-DW-1){sum_s[DW]}}, sum_s};
      OP_SUB:  res_w = {{(ACCW-DW-1){diff_s[DW]}}, diff_s};
      OP_MUL:  res_w = {{(ACCW-2*DW){prod_sh[2*DW-1]}}, prod_sh};
      OP_DOT:  res_w = acc_sum >>> shift_q;
      default: res_w = {{(ACCW-DW){max_s[DW-1]}}, max_s};
    endcase
    res_c = res_w[DW-1:0];
    if (sat_q) begin
      if (res_w > SAT_HI)      res_c = SAT_HI[DW-1:0];
      else if (res_w < SAT_LO) res_c = SAT_LO[DW-1:0];
    end
    base_in = AW'(tile_i) * AW'(TILE * MEM_COLS) + AW'(tile_j) * AW'(TILE);
    legal   = (op <= 3'd4);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sat_d    = sat_q;
    shift_d  = shift_q;
    base_d   = base_q;
    row_d    = row_q;
    addr_d   = addr_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    v1_d     = 1'b0;
    last1_d  = 1'b0;
    addr1_d  = addr1_q;
    we_d     = 1'b0;
    c_addr_d = c_addr_q;
    din_d    = din_q;

    // Write stage: data returned this cycle belongs to the address issued last cycle.
    if (v1_q) acc_d = acc_sum;
    if (v1_q && op_q != OP_DOT) begin
      we_d     = 1'b1;
      c_addr_d = addr1_q;
      din_d    = res_c;
    end
    if (v1_q && last1_q && op_q == OP_DOT) begin
      we_d     = 1'b1;
      c_addr_d = base_q;
      din_d    = res_c;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        if (start) begin
          if (legal) begin
            state_d = ST_READ;
            op_d    = op_e'(op);
            sat_d   = sat_en;
            shift_d = shift;
            base_d  = base_in;
            row_d   = base_in;
            addr_d  = base_in;
            col_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_READ: begin
        v1_d    = 1'b1;
        addr1_d = addr_q;
        last1_d = (cnt_q == CW'(N-1));
        if (cnt_q == CW'(N-1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (col_q == CLW'(TILE-1)) begin
            col_d  = '0;
            row_d  = row_q + AW'(MEM_COLS);
            addr_d = row_q + AW'(MEM_COLS);
          end else begin
            col_d  = col_q + CLW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(1)) state_d = ST_DONE;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      sat_q    <= 1'b0;
      shift_q  <= '0;
      base_q   <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      addr1_q  <= '0;
      we_q     <= 1'b0;
      c_addr_q <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sat_q    <= sat_d;
      shift_q  <= shift_d;
      base_q   <= base_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      addr1_q  <= addr1_d;
      we_q     <= we_d;
      c_addr_q <= c_addr_d;
      din_q    <= din_d;
    end
  end

  assign sram_a_addr = addr_q;
  assign sram_b_addr = addr_q;
  assign sram_c_we   = we_q;
  assign sram_c_addr = c_addr_q;
  assign sram_c_din  = din_q;
  assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_tile_engine.sv
// Bench for tile_engine: behavioural SRAMs, integer reference model and a
// write/done scoreboard checked against cycle, address and data.
module tb_tile_engine;

  localparam int DW = 8, AW = 10, TILE = 4, MEM_COLS = 32, TIW = 3, ACCW = 32;
  localparam int N = TILE * TILE;
  localparam int SW = $clog2(DW);

  logic           clk = 1'b0;
  logic           rst, start, sat_en;
  logic [2:0]     op;
  logic [TIW-1:0] tile_i, tile_j;
  logic [SW-1:0]  shift;
  logic [AW-1:0]  sram_a_addr, sram_b_addr, sram_c_addr;
  logic [DW-1:0]  sram_a_dout, sram_b_dout, sram_c_din;
  logic           sram_c_we, busy, done, err;

  tile_engine #(.DW(DW), .AW(AW), .TILE(TILE), .MEM_COLS(MEM_COLS), .TIW(TIW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .tile_i(tile_i), .tile_j(tile_j),
    .sat_en(sat_en), .shift(shift),
    .sram_a_addr(sram_a_addr), .sram_b_addr(sram_b_addr),
    .sram_a_dout(sram_a_dout), .sram_b_dout(sram_b_dout),
    .sram_c_we(sram_c_we), .sram_c_addr(sram_c_addr), .sram_c_din(sram_c_din),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem_a [1<<AW];
  logic [DW-1:0] mem_b [1<<AW];
  always @(posedge clk) begin
    sram_a_dout <= mem_a[sram_a_addr];
    sram_b_dout <= mem_b[sram_b_addr];
  end

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; int err; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  wr_t wr_e;
  dn_t dn_e;

  int n_chk = 0, n_pass = 0;
  int last_addr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int addr_of(input int ti, input int tj, input int n);
    return (ti*TILE*MEM_COLS + tj*TILE + (n/TILE)*MEM_COLS + n%TILE) % (1<<AW);
  endfunction

  function automatic int sx(input logic [DW-1:0] x);
    int r;
    r = $signed(x);
    return r;
  endfunction

  function automatic int fin(input int v, input int sat);
    int r;
    r = v;
    if (sat != 0) begin
      if (r > (1<<(DW-1))-1) r = (1<<(DW-1))-1;
      if (r < -(1<<(DW-1)))  r = -(1<<(DW-1));
    end
    return r & ((1<<DW)-1);
  endfunction

  task automatic fill(input int a, input int b);
    for (int i = 0; i < (1<<AW); i++) begin
      mem_a[i] = DW'(a);
      mem_b[i] = DW'(b);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < (1<<AW); i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  // Called at a negedge; drives start for one cycle and returns at the negedge of S+1.
  task automatic run_cmd(input int o, input int ti, input int tj, input int sat, input int sh,
                         output int s);
    int a, b, v, sum, ad;
    s      = cyc;
    op     = 3'(o);
    tile_i = TIW'(ti);
    tile_j = TIW'(tj);
    sat_en = (sat != 0);
    shift  = SW'(sh);
    start  = 1'b1;
    if (o > 4) begin
      dn_q.push_back('{s + 1, 1});
    end else begin
      sum = 0;
      for (int n = 0; n < N; n++) begin
        ad = addr_of(ti, tj, n);
        a  = sx(mem_a[ad]);
        b  = sx(mem_b[ad]);
        case (o)
          0:       v = a + b;
          1:       v = a - b;
          2:       v = (a * b) >>> sh;
          3:       v = 0;
          default: v = (a > b) ? a : b;
        endcase
        sum += a * b;
        if (o != 3) wr_q.push_back('{s + 3 + n, ad, fin(v, sat)});
      end
      if (o == 3) wr_q.push_back('{s + 2 + N, addr_of(ti, tj, 0), fin(sum >>> sh, sat)});
      dn_q.push_back('{s + 3 + N, 0});
      last_addr = addr_of(ti, tj, N-1);
    end
    @(negedge clk);
    start  = 1'b0;
    op     = 3'($urandom_range(0, 7));
    tile_i = TIW'($urandom);
    tile_j = TIW'($urandom);
    sat_en = 1'($urandom);
    shift  = SW'($urandom);
  endtask

  task automatic wait_done();
    int seen;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  always @(negedge clk) begin
    if (sram_c_we === 1'b1) begin
      if (wr_q.size() == 0) chk("we_unexp", sram_c_we, 0);
      else begin
        wr_e = wr_q.pop_front();
        chk("wr_cyc", cyc, wr_e.cyc);
        chk("wr_addr", sram_c_addr, wr_e.addr);
        chk("wr_data", sram_c_din, wr_e.data);
      end
    end
    if (done === 1'b1) begin
      if (dn_q.size() == 0) chk("done_unexp", done, 0);
      else begin
        dn_e = dn_q.pop_front();
        chk("done_cyc", cyc, dn_e.cyc);
        chk("done_err", err, dn_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; op = '0; tile_i = '0; tile_j = '0; sat_en = 1'b0; shift = '0;
    fill_rand();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", sram_c_we, 0);
    chk("rst_a_addr", sram_a_addr, 0);
    chk("rst_b_addr", sram_b_addr, 0);
    chk("rst_c_addr", sram_c_addr, 0);
    chk("rst_din", sram_c_din, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Address sweep on tile (1,2)
    run_cmd(0, 1, 2, 1, 0, s);
    chk("sweep_busy_first", busy, 1);
    for (int k = 1; k <= N; k++) begin
      if (k > 1) @(negedge clk);
      chk("sweep_a_addr", sram_a_addr, addr_of(1, 2, k-1));
      chk("sweep_b_addr", sram_b_addr, addr_of(1, 2, k-1));
    end
    repeat (2) @(negedge clk);
    chk("sweep_busy_last", busy, 1);
    wait_done();
    chk("sweep_busy_done", busy, 0);

    // Saturation and wrap; each command starts in the previous done cycle
    fill(100, 50);
    run_cmd(0, 0, 0, 1, 0, s); wait_done();
    run_cmd(0, 3, 5, 0, 0, s); wait_done();
    fill(-100, 50);
    run_cmd(1, 2, 1, 1, 0, s); wait_done();

    // MUL and MAX
    fill(20, -7);
    run_cmd(2, 0, 1, 1, 2, s); wait_done();
    fill(-128, -128);
    run_cmd(2, 1, 1, 1, 0, s); wait_done();
    fill(-3, 5);
    run_cmd(4, 6, 2, 1, 3, s); wait_done();

    // DOT
    fill(2, 3);
    run_cmd(3, 2, 3, 1, 0, s); wait_done();
    fill(10, 10);
    run_cmd(3, 4, 0, 1, 0, s); wait_done();
    run_cmd(3, 4, 0, 1, 4, s); wait_done();

    // Mixed random data
    fill_rand();
    run_cmd(0, 7, 7, 0, 0, s); wait_done();
    run_cmd(1, 3, 6, 1, 0, s); wait_done();
    run_cmd(2, 5, 1, 0, 3, s); wait_done();
    run_cmd(2, 2, 2, 1, 5, s); wait_done();
    run_cmd(4, 1, 4, 0, 0, s); wait_done();
    run_cmd(3, 6, 3, 0, 7, s); wait_done();
    run_cmd(3, 0, 5, 1, 2, s); wait_done();

    // Illegal op: err pulse, no address change
    repeat (2) @(negedge clk);
    run_cmd(6, 2, 2, 0, 0, s);
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_a_addr", sram_a_addr, last_addr);
    @(negedge clk);
    chk("ill_done_clr", done, 0);
    chk("ill_b_addr", sram_b_addr, last_addr);

    // start while busy is ignored
    @(negedge clk);
    run_cmd(0, 1, 1, 0, 0, s);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd2; tile_i = 3'd5; tile_j = 3'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);

    // Reset in the middle of an ADD
    run_cmd(0, 2, 2, 1, 0, s);
    repeat (7) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", sram_c_we, 0);
    wr_q.delete();
    dn_q.delete();
    @(negedge clk);
    chk("mid_rst_addr", sram_a_addr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_cmd(1, 1, 3, 0, 0, s);
    wait_done();

    repeat (3) @(negedge clk);
    chk("wr_left", wr_q.size(), 0);
    chk("done_left", dn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
